// File: rtl/onehot_decoder_scan_if.sv
// ---------------------------------------------------------------------------
// onehot_decoder_scan_if
// Command and output bundle for the one-hot decoder/scanner.
//   in_valid  : command valid                          (master -> slave)
//   in_ready  : command accepted on in_valid&in_ready  (slave  -> master)
//   mode      : 00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 ONESHOT
//   sel       : decode index or scan start index
//   dwell     : cycles-per-step minus one
//   out       : registered one-hot line vector, or all zero
//   out_valid : high whenever out is non-zero
//   busy      : high while a scan is running
// The master modport drives commands; the slave modport is the decoder.
// ---------------------------------------------------------------------------
interface onehot_decoder_scan_if #(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 4
);
    localparam int OUT_W = 2 ** SEL_W;

    logic               in_valid;
    logic               in_ready;
    logic [1:0]         mode;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic               out_valid;
    logic               busy;

    modport master (
        output in_valid, mode, sel, dwell,
        input  in_ready, out, out_valid, busy
    );

    modport slave (
        input  in_valid, mode, sel, dwell,
        output in_ready, out, out_valid, busy
    );
endinterface

// File: rtl/onehot_decoder_scan.sv
// ---------------------------------------------------------------------------
// onehot_decoder_scan
// Registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready command
// port, a block enable and three auto-scan modes (up, down, one-shot).
// Scan modes step the active line, holding each line dwell+1 cycles.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : block enable; low forces IDLE with output cleared
//   bus   : command/output bundle (slave side), see onehot_decoder_scan_if
// ---------------------------------------------------------------------------
module onehot_decoder_scan #(
    parameter  int SEL_W   = 4,
    parameter  int DWELL_W = 4,
    localparam int OUT_W   = 2 ** SEL_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    onehot_decoder_scan_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_SCAN = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_ONESHOT   = 2'b11
    } mode_e;

    localparam logic [SEL_W-1:0]   IDX_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0]   IDX_MAX  = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0]   IDX_ZERO = {SEL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DW_ONE   = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DW_ZERO  = {DWELL_W{1'b0}};
    localparam logic [OUT_W-1:0]   OUT_ZERO = {OUT_W{1'b0}};

    state_e             state_q;
    mode_e              mode_q;
    logic [SEL_W-1:0]   idx_q;
    logic [DWELL_W-1:0] dcnt_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [OUT_W-1:0]   out_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               accept_s;
    logic [SEL_W-1:0]   idx_step_s;

    // Single set bit at position idx; never more than one line active.
    function automatic logic [OUT_W-1:0] onehot_f(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] v;
        v      = OUT_ZERO;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign bus.in_ready  = en & (state_q != ST_SCAN);
    assign accept_s      = bus.in_valid & bus.in_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

    // Next index at a scan step; SEL_W-bit arithmetic gives the natural wrap.
    always_comb begin
        idx_step_s = idx_q + IDX_ONE;
        if (mode_q == MODE_SCAN_DOWN) begin
            idx_step_s = idx_q - IDX_ONE;
        end else begin
            idx_step_s = idx_q + IDX_ONE;
        end
    end

    // Control FSM with registered one-hot output, valid and busy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_DIRECT;
            idx_q       <= IDX_ZERO;
            dcnt_q      <= DW_ZERO;
            dwell_q     <= DW_ZERO;
            out_q       <= OUT_ZERO;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (!en) begin
            // Disable wins over any step or command in the same cycle.
            state_q     <= ST_IDLE;
            idx_q       <= IDX_ZERO;
            dcnt_q      <= DW_ZERO;
            out_q       <= OUT_ZERO;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept_s) begin
                        mode_q      <= mode_e'(bus.mode);
                        idx_q       <= bus.sel;
                        dcnt_q      <= bus.dwell;
                        dwell_q     <= bus.dwell;
                        out_q       <= onehot_f(bus.sel);
                        out_valid_q <= 1'b1;
                        if (mode_e'(bus.mode) == MODE_DIRECT) begin
                            state_q <= ST_HOLD;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_SCAN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_SCAN: begin
                    if (dcnt_q != DW_ZERO) begin
                        dcnt_q <= dcnt_q - DW_ONE;
                    end else if ((mode_q == MODE_ONESHOT) && (idx_q == IDX_MAX)) begin
                        // One-shot ends after the top line instead of wrapping.
                        state_q     <= ST_IDLE;
                        idx_q       <= IDX_ZERO;
                        out_q       <= OUT_ZERO;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        dcnt_q <= dwell_q;
                        idx_q  <= idx_step_s;
                        out_q  <= onehot_f(idx_step_s);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_q       <= OUT_ZERO;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_decoder_scan.sv
// ---------------------------------------------------------------------------
// tb_onehot_decoder_scan
// Directed bench for onehot_decoder_scan. Inputs change and outputs are
// sampled on the falling clock edge, half a period away from the active edge.
// ---------------------------------------------------------------------------
module tb_onehot_decoder_scan;

    localparam int SEL_W   = 4;
    localparam int DWELL_W = 4;

    logic clk;
    logic rst_n;
    logic en;

    int n_checks;
    int n_fails;

    onehot_decoder_scan_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    onehot_decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] m, input logic [3:0] s, input logic [3:0] d);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.sel      = s;
        bus.dwell    = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [15:0] exp_out, input logic exp_busy);
        check_val({tag, "_out"},  32'(bus.out),       32'(exp_out));
        check_val({tag, "_ov"},   32'(bus.out_valid), 32'(exp_out != 16'h0000));
        check_val({tag, "_busy"}, 32'(bus.busy),      32'(exp_busy));
    endtask

    logic [15:0] exp_t2 [0:6];
    logic [15:0] exp_t3 [0:3];

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        rst_n        = 1'b0;
        en           = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode     = 2'b00;
        bus.sel      = 4'd0;
        bus.dwell    = 4'd0;

        exp_t2[0] = 16'h4000; exp_t2[1] = 16'h4000; exp_t2[2] = 16'h8000;
        exp_t2[3] = 16'h8000; exp_t2[4] = 16'h0001; exp_t2[5] = 16'h0001;
        exp_t2[6] = 16'h0002;
        exp_t3[0] = 16'h0002; exp_t3[1] = 16'h0001;
        exp_t3[2] = 16'h8000; exp_t3[3] = 16'h4000;

        // Reset state
        step();
        check_outs("rst", 16'h0000, 1'b0);
        check_val("rst_rdy", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check_outs("rst_rel", 16'h0000, 1'b0);

        // T1: DIRECT sweep, back to back
        bus.in_valid = 1'b1;
        bus.mode     = 2'b00;
        for (int i = 0; i < 16; i++) begin
            bus.sel = 4'(i);
            check_val("t1_rdy", 32'(bus.in_ready), 32'd1);
            step();
            check_outs("t1", 16'h0001 << i, 1'b0);
        end
        bus.in_valid = 1'b0;
        step();
        check_outs("t1_hold", 16'h8000, 1'b0);

        // T2: SCAN_UP wrap, sel=14 dwell=1
        send(2'b01, 4'd14, 4'd1);
        for (int i = 0; i < 7; i++) begin
            check_outs("t2", exp_t2[i], 1'b1);
            check_val("t2_rdy", 32'(bus.in_ready), 32'd0);
            step();
        end
        en = 1'b0;
        step();
        check_outs("t2_off", 16'h0000, 1'b0);
        en = 1'b1;

        // T3: SCAN_DOWN wrap, sel=1 dwell=0
        send(2'b10, 4'd1, 4'd0);
        for (int i = 0; i < 4; i++) begin
            check_outs("t3", exp_t3[i], 1'b1);
            step();
        end
        en = 1'b0;
        step();
        en = 1'b1;

        // T4: ONESHOT sel=13 dwell=0, ends without wrapping
        send(2'b11, 4'd13, 4'd0);
        check_outs("t4_a", 16'h2000, 1'b1);
        step();
        check_outs("t4_b", 16'h4000, 1'b1);
        step();
        check_outs("t4_c", 16'h8000, 1'b1);
        step();
        check_outs("t4_end", 16'h0000, 1'b0);
        check_val("t4_rdy", 32'(bus.in_ready), 32'd1);
        step();
        check_outs("t4_idle", 16'h0000, 1'b0);

        // T5: en drop during SCAN_UP at idx=5, command with en low refused
        send(2'b01, 4'd3, 4'd0);
        check_outs("t5_a", 16'h0008, 1'b1);
        step();
        check_outs("t5_b", 16'h0010, 1'b1);
        step();
        check_outs("t5_c", 16'h0020, 1'b1);
        en           = 1'b0;
        bus.in_valid = 1'b1;
        bus.mode     = 2'b00;
        bus.sel      = 4'd9;
        check_val("t5_rdy", 32'(bus.in_ready), 32'd0);
        step();
        check_outs("t5_off", 16'h0000, 1'b0);
        step();
        check_outs("t5_noacc", 16'h0000, 1'b0);
        bus.in_valid = 1'b0;
        en           = 1'b1;
        step();

        // T6: async reset in the middle of a scan
        send(2'b01, 4'd0, 4'd2);
        step();
        check_outs("t6_pre", 16'h0001, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_outs("t6_rst", 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_outs("t6_rel", 16'h0000, 1'b0);
        send(2'b00, 4'd3, 4'd0);
        check_outs("t6_dir", 16'h0008, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
